// File: rtl/imm_ext_pipe.sv
// Pipelined immediate extender: mask, sign/zero extend, left shift, then a valid/ready
// output register with one skid entry. Define IMM_EXT_OVF_EN to add the ovf output.
module imm_ext_pipe #(
  parameter int unsigned IN_W  = 20,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned LEN_W = $clog2(IN_W + 1),
  parameter int unsigned SH_W  = $clog2(OUT_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  imm_in,
  input  logic [LEN_W-1:0] field_len,
  input  logic             sign_en,
  input  logic [SH_W-1:0]  shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] imm_out
`ifdef IMM_EXT_OVF_EN
  ,
  output logic             ovf
`endif
);

`ifdef IMM_EXT_OVF_EN
  localparam int unsigned EntW = OUT_W + 1;
`else
  localparam int unsigned EntW = OUT_W;
`endif

  // Encoding puts out_valid in bit 1 and in_ready in bit 0, so both are plain flop outputs.
  typedef enum logic [1:0] {
    StEmpty = 2'b01,
    StOne   = 2'b11,
    StTwo   = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic [EntW-1:0]   oreg_q, oreg_d;
  logic [EntW-1:0]   skid_q, skid_d;
  logic [EntW-1:0]   new_ent;
  logic [LEN_W-1:0]  len_c;
  logic [OUT_W-1:0]  in_pad;
  logic [OUT_W-1:0]  ext;
  logic [OUT_W-1:0]  shifted;
  logic              fill;
  logic              in_xfer;
  logic              out_xfer;

  // Extension and shift datapath.
  always_comb begin
    len_c  = (field_len > LEN_W'(IN_W)) ? LEN_W'(IN_W) : field_len;
    in_pad = '0;
    in_pad[IN_W-1:0] = imm_in;
    fill = 1'b0;
    for (int i = 0; i < int'(IN_W); i++) begin
      if (sign_en && (int'(len_c) == i + 1)) fill = imm_in[i];
    end
    ext = '0;
    for (int i = 0; i < int'(OUT_W); i++) begin
      ext[i] = (i < int'(len_c)) ? in_pad[i] : fill;
    end
    shifted = ext << shamt;
  end

`ifdef IMM_EXT_OVF_EN
  logic [OUT_W-1:0] top_mask;
  logic             ovf_new;

  // Bits shifted out must all equal the fill value for the shift to be lossless.
  always_comb begin
    top_mask = ~({OUT_W{1'b1}} >> shamt);
    ovf_new  = |((ext ^ {OUT_W{fill}}) & top_mask);
    new_ent  = {ovf_new, shifted};
  end

  assign ovf = oreg_q[OUT_W];
`else
  assign new_ent = shifted;
`endif

  assign out_valid = state_q[1];
  assign in_ready  = state_q[0];
  assign imm_out   = oreg_q[OUT_W-1:0];
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    oreg_d  = oreg_q;
    skid_d  = skid_q;
    case (state_q)
      StEmpty: begin
        if (in_xfer) begin
          oreg_d  = new_ent;
          state_d = StOne;
        end
      end
      StOne: begin
        if (in_xfer && out_xfer) begin
          oreg_d = new_ent;
        end else if (in_xfer) begin
          skid_d  = new_ent;
          state_d = StTwo;
        end else if (out_xfer) begin
          state_d = StEmpty;
        end
      end
      StTwo: begin
        if (out_xfer) begin
          oreg_d  = skid_q;
          state_d = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
      oreg_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      oreg_q  <= oreg_d;
      skid_q  <= skid_d;
    end
  end

endmodule
